// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: round-robin grant among six sources into a one-entry output register.
// Define WB_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (no rotating pointer).
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int N_REQ  = 6
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ*RD_W-1:0]   req_rd,
  output logic [N_REQ-1:0]        req_ready,
  output logic [2:0]              wb_sel,
  output logic                    wb_valid,
  output logic [RD_W-1:0]         wb_rd,
  output logic [DATA_W-1:0]       wb_data,
  input  logic                    wb_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [2:0]        start;
  logic [2:0]        win;
  logic              found;
  logic [DATA_W-1:0] win_data;
  logic [RD_W-1:0]   win_rd;
  logic              arb_open;
  logic              grant;
  logic              load;

`ifdef WB_ARB_FIXED_PRIO_EN
  assign start = 3'd0;
`else
  logic [2:0] ptr;
  assign start = ptr;
`endif

  // Search upward from start, wrapping past index N_REQ-1 back to 0.
  always_comb begin
    logic [3:0] sum;
    logic [2:0] idx;
    win   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sum = {1'b0, start} + k[3:0];
      idx = (sum >= 4'(N_REQ)) ? 3'(sum - 4'(N_REQ)) : sum[2:0];
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    win_data = '0;
    win_rd   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win == i[2:0]) begin
        win_data = req_data[i*DATA_W +: DATA_W];
        win_rd   = req_rd[i*RD_W +: RD_W];
      end
    end
  end

  assign arb_open = (state == EMPTY) || wb_ready;
  assign grant    = arb_open && found;
  // rd==0 is accepted (handshake completes, pointer moves) but never written.
  assign load     = grant && (win_rd != '0);

  always_comb begin
    state_nxt = state;
    if (arb_open) begin
      state_nxt = load ? FULL : EMPTY;
    end
  end

  assign wb_valid  = (state == FULL);
  assign req_ready = (RST_N && grant) ? (N_REQ'(1) << win) : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wb_sel  <= '0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else if (load) begin
      wb_sel  <= win;
      wb_rd   <= win_rd;
      wb_data <= win_data;
    end
  end

`ifndef WB_ARB_FIXED_PRIO_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr <= '0;
    end else if (grant) begin
      ptr <= (win == 3'(N_REQ - 1)) ? 3'd0 : win + 3'd1;
    end
  end
`endif

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port among up to six writeback sources (ALU, load unit, CSR, multiplier, divider, spare).
- Round-robin arbitration with a valid/ready handshake per source.
- Drives the select of the 6-to-1 writeback data mux and holds the winning write in a one-entry output register until the register file accepts it.
- Sits between the execute/memory-stage producers and the register-file write port.

Parameters:
- DATA_W, 32, width of writeback data.
- RD_W, 5, width of destination register index.
- N_REQ, 6, number of requesters; fixed at 6 to match a 3-bit select (values other than 6 unsupported).

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  reset, asynchronous assert, active-low.
- req_valid  input  6  per-source write request.
- req_data  input  6*DATA_W  flattened source data; source i at [i*DATA_W +: DATA_W].
- req_rd  input  6*RD_W  flattened destination index; source i at [i*RD_W +: RD_W].
- req_ready  output  6  one-hot grant/accept; a transfer on source i is valid & ready.
- wb_sel  output  3  index of the source in the output register; feeds the 6:1 mux select.
- wb_valid  output  1  output register holds a write.
- wb_rd  output  RD_W  registered destination index.
- wb_data  output  DATA_W  registered write data.
- wb_ready  input  1  register file accepts the write this cycle.

Behaviour:
- Reset (RST_N low, asynchronous):
  - wb_valid=0, wb_sel=0, wb_rd=0, wb_data=0, req_ready=0.
  - Round-robin pointer = 0, meaning source 0 has highest priority first.
  - Reset mid-transfer discards the held write; no write is emitted after reset release.
- States:
  - EMPTY (wb_valid=0): arbitration open.
  - FULL (wb_valid=1): holding a write.
- Transitions:
  - EMPTY -> FULL on any grant.
  - FULL -> EMPTY on wb_ready with no new grant.
  - FULL -> FULL on wb_ready with a new grant, giving back-to-back throughput of 1 write per cycle.
  - FULL with wb_ready=0: hold; wb_sel, wb_rd and wb_data stay stable; req_ready=0.
- Arbitration:
  - Combinational, evaluated when the state is EMPTY or (FULL and wb_ready).
  - Winner = first requesting index at or after the pointer, searching upward modulo 6 (index 5 wraps to 0).
  - req_ready is one-hot on the winner, all zero otherwise; never more than one bit set.
- Pointer update: on a grant to i, pointer <= (i+1) mod 6 (5 wraps to 0). Unchanged when there is no grant.
- Latency: a source granted in cycle t appears on wb_valid/wb_data in cycle t+1.
- rd==0: the request is granted (req_ready=1, pointer advances) but not loaded. The state goes to EMPTY, or stays EMPTY, as if no grant occurred; wb_valid is not asserted for it.
- A requester may drop req_valid without a grant; no penalty.
- Data is sampled only on the grant cycle.

Optional Feature:
- Macro: WB_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the pointer register is removed and wb_sel ordering is strictly 0 > 1 > ... > 5.
- Undefined (default): round-robin as described above.

Test Plan:
- Reset check: RST_N=0 mid-FULL with wb_data=0xDEADBEEF -> all outputs 0 immediately (asynchronous); after release, wb_valid stays 0 until a new request.
- Single source: req_valid=000100, rd=7, data=0x12345678, wb_ready=1 -> req_ready=000100 in cycle t; cycle t+1 gives wb_valid=1, wb_sel=2, wb_rd=7, wb_data=0x12345678.
- Round-robin: all six valid continuously, wb_ready=1 -> grant order 0,1,2,3,4,5,0 with one grant per cycle. With WB_ARB_FIXED_PRIO_EN -> source 0 every cycle.
- Backpressure: FULL with source 3 data 0xAA, wb_ready=0 for 4 cycles, source 1 requesting -> req_ready=0, outputs stable at sel=3/0xAA; first wb_ready=1 grants source 1.
- Wrap: pointer at 5, req_valid=100001 -> grant 5, then 0; pointer returns to 1.
- rd=0: source 4 requests with rd=0 -> req_ready[4]=1, wb_valid stays 0, next grant search starts at 5.
